seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for the Nexys A7 8-digit common-anode 7-segment display.

---
 rtl/bc_display_pkg.sv | 38 +++
 rtl/seg7_char_decoder.sv | 48 ++++
 rtl/seg7_scan_driver.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bc_display_pkg.sv
// rtl/bc_display_pkg.sv - character codes and digit/segment types for the 7-segment scan driver
package bc_display_pkg;

    localparam logic [4:0] CH_A         = 5'h0A;
    localparam logic [4:0] CH_b         = 5'h0B;
    localparam logic [4:0] CH_C         = 5'h0C;
    localparam logic [4:0] CH_d         = 5'h0D;
    localparam logic [4:0] CH_E         = 5'h0E;
    localparam logic [4:0] CH_F         = 5'h0F;
    localparam logic [4:0] CH_BLANK     = 5'h10;
    localparam logic [4:0] CH_P         = 5'h11;
    localparam logic [4:0] CH_S         = 5'h12;
    localparam logic [4:0] CH_U         = 5'h13;
    localparam logic [4:0] CH_r         = 5'h14;
    localparam logic [4:0] CH_n         = 5'h15;
    localparam logic [4:0] CH_o         = 5'h16;
    localparam logic [4:0] CH_L         = 5'h17;
    localparam logic [4:0] CH_t         = 5'h18;
    localparam logic [4:0] CH_G         = 5'h19;
    localparam logic [4:0] CH_H         = 5'h1A;
    localparam logic [4:0] CH_I         = 5'h1B;
    localparam logic [4:0] CH_J         = 5'h1C;
    localparam logic [4:0] CH_DASH      = 5'h1D;
    localparam logic [4:0] CH_UNDER     = 5'h1E;
    localparam logic [4:0] CH_BLANK_ALT = 5'h1F;

    typedef struct packed {
        logic       en;
        logic [4:0] chr;
        logic       dp_n;
    } digit_code_t;

    // Segments {g,f,e,d,c,b,a}, active-low
    typedef logic [6:0] seg_t;

    localparam digit_code_t DIGIT_OFF = '{en: 1'b0, chr: CH_BLANK, dp_n: 1'b1};

endpackage

// File: rtl/seg7_char_decoder.sv
// rtl/seg7_char_decoder.sv - combinational 5-bit character code to active-low segment pattern
module seg7_char_decoder
    import bc_display_pkg::*;
(
    input  logic [4:0] chr,
    output seg_t       seg
);

    always_comb begin
        seg = 7'h7F;
        case (chr)
            5'h00:        seg = 7'h40;
            5'h01:        seg = 7'h79;
            5'h02:        seg = 7'h24;
            5'h03:        seg = 7'h30;
            5'h04:        seg = 7'h19;
            5'h05:        seg = 7'h12;
            5'h06:        seg = 7'h02;
            5'h07:        seg = 7'h78;
            5'h08:        seg = 7'h00;
            5'h09:        seg = 7'h10;
            CH_A:         seg = 7'h08;
            CH_b:         seg = 7'h03;
            CH_C:         seg = 7'h46;
            CH_d:         seg = 7'h21;
            CH_E:         seg = 7'h06;
            CH_F:         seg = 7'h0E;
            CH_BLANK:     seg = 7'h7F;
            CH_P:         seg = 7'h0C;
            CH_S:         seg = 7'h12;
            CH_U:         seg = 7'h41;
            CH_r:         seg = 7'h2F;
            CH_n:         seg = 7'h2B;
            CH_o:         seg = 7'h23;
            CH_L:         seg = 7'h47;
            CH_t:         seg = 7'h07;
            CH_G:         seg = 7'h42;
            CH_H:         seg = 7'h09;
            CH_I:         seg = 7'h4F;
            CH_J:         seg = 7'h61;
            CH_DASH:      seg = 7'h3F;
            CH_UNDER:     seg = 7'h77;
            CH_BLANK_ALT: seg = 7'h7F;
            default:      seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit multiplexed 7-segment driver with frame latch and ghost blanking (option: SEG7_BLINK_EN)
module seg7_scan_driver
    import bc_display_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 8_000,
    parameter int BLANK_CYC = 2
`ifdef SEG7_BLINK_EN
    ,
    parameter int BLINK_HZ  = 2
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] d1,
    input  logic [6:0] d2,
    input  logic [6:0] d3,
    input  logic [6:0] d4,
    input  logic [6:0] d5,
    input  logic [6:0] d6,
    input  logic [6:0] d7,
    input  logic [6:0] d8,
`ifdef SEG7_BLINK_EN
    input  logic [7:0] blink,
`endif
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       frame
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = $clog2(DIV);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_t;

    slot_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             tick, load;
    digit_code_t      d_in     [8];
    digit_code_t      shadow_q [8];
    digit_code_t      sel_code;
    seg_t             sel_seg;
    logic             digit_dark;
    logic [7:0]       an_d, seg_d;
    logic             frame_d;

    assign d_in[0] = digit_code_t'(d1);
    assign d_in[1] = digit_code_t'(d2);
    assign d_in[2] = digit_code_t'(d3);
    assign d_in[3] = digit_code_t'(d4);
    assign d_in[4] = digit_code_t'(d5);
    assign d_in[5] = digit_code_t'(d6);
    assign d_in[6] = digit_code_t'(d7);
    assign d_in[7] = digit_code_t'(d8);

    assign tick  = (cnt_q == CNT_W'(DIV - 1));
    assign load  = tick && (idx_q == 3'd7);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    assign idx_d = tick ? idx_q + 3'd1 : idx_q;

    // Outputs are registered against the next slot position, so the digit
    // shown on the first cycle of a frame must come straight from the inputs.
    assign sel_code = load ? d_in[idx_d] : shadow_q[idx_d];

    seg7_char_decoder u_decoder (
        .chr (sel_code.chr),
        .seg (sel_seg)
    );

`ifdef SEG7_BLINK_EN
    localparam int BLINK_PER = CLK_HZ / BLINK_HZ;
    localparam int BLINK_W   = $clog2(BLINK_PER);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [7:0]         blink_sh_q;
    logic               sel_blink;

    assign blink_cnt_d = (blink_cnt_q == BLINK_W'(BLINK_PER - 1)) ? '0 : blink_cnt_q + 1'b1;
    assign sel_blink   = load ? blink[idx_d] : blink_sh_q[idx_d];
    assign digit_dark  = sel_blink && (blink_cnt_d >= BLINK_W'(BLINK_PER / 2));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_sh_q  <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            if (load) begin
                blink_sh_q <= blink;
            end
        end
    end
`else
    assign digit_dark = 1'b0;
`endif

    always_comb begin
        state_d = ST_BLANK;
        an_d    = 8'hFF;
        seg_d   = 8'hFF;
        frame_d = load;
        if (cnt_d >= CNT_W'(BLANK_CYC)) begin
            state_d = ST_DRIVE;
        end
        if (state_d == ST_DRIVE && sel_code.en && !digit_dark) begin
            an_d  = ~(8'b1 << idx_d);
            seg_d = {sel_code.dp_n, sel_seg};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            an      <= 8'hFF;
            seg     <= 8'hFF;
            frame   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an      <= an_d;
            seg     <= seg_d;
            frame   <= frame_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= DIGIT_OFF;
            end
        end else if (load) begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= d_in[i];
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver against a frame-level display model
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int FRAME = 8 * DIV;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] d [8];
    logic [7:0] an, seg;
    logic       frame;

    int n_assert = 0;
    int n_fail   = 0;
    int k;
    logic [6:0] sh [8];

    // Active-high {g,f,e,d,c,b,a} glyphs, indexed by character code
    logic [6:0] font [32] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
        7'h00, 7'h73, 7'h6D, 7'h3E, 7'h50, 7'h54, 7'h5C, 7'h38,
        7'h78, 7'h3D, 7'h76, 7'h30, 7'h1E, 7'h40, 7'h08, 7'h00
    };

    seg7_scan_driver #(
        .CLK_HZ    (800),
        .SCAN_HZ   (100),
        .BLANK_CYC (2)
`ifdef SEG7_BLINK_EN
        ,
        .BLINK_HZ  (1)
`endif
    ) dut (
        .clock (clock),
        .reset (reset),
        .d1    (d[0]),
        .d2    (d[1]),
        .d3    (d[2]),
        .d4    (d[3]),
        .d5    (d[4]),
        .d6    (d[5]),
        .d7    (d[6]),
        .d8    (d[7]),
`ifdef SEG7_BLINK_EN
        .blink (8'h00),
`endif
        .an    (an),
        .seg   (seg),
        .frame (frame)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < 8; i++) sh[i] = 7'b0_10000_1;
    endtask

    // One clock of the display model: k counts edges since reset release,
    // a frame boundary every 64 edges captures the inputs seen at that edge.
    task automatic step();
        int p, s;
        logic [7:0] exp_an, exp_seg;
        @(posedge clock);
        k++;
        if (k % FRAME == 0) begin
            for (int i = 0; i < 8; i++) sh[i] = d[i];
        end
        @(negedge clock);
        p = k % DIV;
        s = (k / DIV) % 8;
        exp_an  = 8'hFF;
        exp_seg = 8'hFF;
        if (p >= 2 && sh[s][6]) begin
            exp_an  = ~(8'd1 << s);
            exp_seg = {sh[s][0], ~font[sh[s][5:1]]};
        end
        chk("an", an, exp_an);
        chk("seg", seg, exp_seg);
        chk("frame", {7'b0, frame}, {7'b0, (k % FRAME == 0)});
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 8; i++) d[i] = 7'h7F;
        model_reset();
        repeat (5) begin
            @(negedge clock);
            chk("rst_an", an, 8'hFF);
            chk("rst_seg", seg, 8'hFF);
            chk("rst_frame", {7'b0, frame}, 8'h00);
        end
        reset = 1'b1;
        repeat (2 * FRAME) step();

        for (int i = 0; i < 8; i++) d[i] = 7'h00;
        d[0] = 7'b1_01000_1;
        repeat (2 * FRAME) step();

        d[7] = 7'b1_00000_0;
        repeat (2 * FRAME) step();

        d[2] = 7'b1_00101_1;
        repeat (FRAME + 20) step();
        d[2] = 7'b1_01001_1;
        repeat (2 * FRAME) step();

        repeat (6 * FRAME) begin
            step();
            if ($urandom_range(0, 7) == 0) d[$urandom_range(0, 7)] = 7'($urandom);
        end

        d[4] = 7'b1_00011_1;
        repeat (2 * FRAME) step();
        for (int i = 0; i < FRAME && !(((k / DIV) % 8) == 4 && (k % DIV) == 4); i++) step();
        chk("pre_rst_slot4_an", an, 8'hEF);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_an", an, 8'hFF);
        chk("async_rst_seg", seg, 8'hFF);
        chk("async_rst_frame", {7'b0, frame}, 8'h00);
        @(negedge clock);
        chk("held_rst_an", an, 8'hFF);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        repeat (2 * FRAME) begin
            step();
            if ($urandom_range(0, 15) == 0) d[$urandom_range(0, 7)] = 7'($urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
